instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 172 +++++++++++++++++
 tb/tb_instr_encoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS-style instructions and writes them sequentially
// into an instruction memory region starting at BASE_ADDR.
// Optional feature macro: ENCODER_ILLEGAL_CHECK_EN (reject illegal op_sel and
// pulse err instead of writing a NOP).
module instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              flush,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              full,
  output logic [ADDR_W-2:0] count,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

  state_t            state_q;
  logic [3:0]        op_q;
  logic [4:0]        rs_q, rt_q, rd_q;
  logic [15:0]       imm_q;
  logic [25:0]       tgt_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              full_q;
  logic              flush_pend_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [31:0]       enc_d;
  logic              accept_c;

  assign in_ready  = (state_q == IDLE) & ~full_q & ~flush;
  assign accept_c  = in_valid & in_ready;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign full      = full_q;
  assign count     = cnt_q;

`ifdef ENCODER_ILLEGAL_CHECK_EN
  logic ill_q;
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Instruction word from the captured fields; unknown ops encode as NOP.
  always_comb begin
    enc_d = 32'h0000_0000;
    case (op_q)
      4'd0:    enc_d = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, 6'b100000};
      4'd1:    enc_d = {6'b000000, rs_q, rt_q, rd_q, 5'b00000, 6'b100100};
      4'd2:    enc_d = {6'b000000, rs_q, 15'b0, 6'b001000};
      4'd3:    enc_d = {6'b100011, rs_q, rt_q, imm_q};
      4'd4:    enc_d = {6'b101011, rs_q, rt_q, imm_q};
      4'd5:    enc_d = {6'b000100, rs_q, rt_q, imm_q};
      4'd6:    enc_d = {6'b000101, rs_q, rt_q, imm_q};
      4'd7:    enc_d = {6'b001000, rs_q, rt_q, imm_q};
      4'd8:    enc_d = {6'b001100, rs_q, rt_q, imm_q};
      4'd9:    enc_d = {6'b000010, tgt_q};
      4'd10:   enc_d = {6'b000011, tgt_q};
      default: enc_d = 32'h0000_0000;
    endcase
  end

  // Control FSM, write pointer, word count and registered memory port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= 4'd0;
      rs_q         <= 5'd0;
      rt_q         <= 5'd0;
      rd_q         <= 5'd0;
      imm_q        <= 16'd0;
      tgt_q        <= 26'd0;
      ptr_q        <= BASE;
      cnt_q        <= '0;
      full_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= BASE;
      mem_wdata_q  <= 32'h0000_0000;
`ifdef ENCODER_ILLEGAL_CHECK_EN
      ill_q        <= 1'b0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          flush_pend_q <= 1'b0;
          if (flush) begin
            ptr_q  <= BASE;
            cnt_q  <= '0;
            full_q <= 1'b0;
          end else if (accept_c) begin
            op_q    <= op_sel;
            rs_q    <= rs;
            rt_q    <= rt;
            rd_q    <= rd;
            imm_q   <= imm;
            tgt_q   <= target;
            state_q <= ENC;
`ifdef ENCODER_ILLEGAL_CHECK_EN
            ill_q   <= (op_sel > 4'd10);
            err_q   <= (op_sel > 4'd10);
`endif
          end
        end
        ENC: begin
          flush_pend_q <= flush_pend_q | flush;
`ifdef ENCODER_ILLEGAL_CHECK_EN
          err_q <= 1'b0;
          if (ill_q) begin
            // Rejected op: no write, but a flush seen so far still rewinds.
            state_q <= IDLE;
            if (flush_pend_q | flush) begin
              ptr_q  <= BASE;
              cnt_q  <= '0;
              full_q <= 1'b0;
            end
          end else begin
            mem_write_q <= 1'b1;
            mem_addr_q  <= ptr_q;
            mem_wdata_q <= enc_d;
            state_q     <= WR;
          end
`else
          mem_write_q <= 1'b1;
          mem_addr_q  <= ptr_q;
          mem_wdata_q <= enc_d;
          state_q     <= WR;
`endif
        end
        WR: begin
          mem_write_q  <= 1'b0;
          flush_pend_q <= 1'b0;
          state_q      <= IDLE;
          if (flush_pend_q | flush) begin
            ptr_q  <= BASE;
            cnt_q  <= '0;
            full_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (ptr_q == LAST) full_q <= 1'b1;
            else               ptr_q  <= ptr_q + STEP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (ADDR_W=4: a four-word region).
module tb_instr_encoder;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op_sel;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          flush;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          full;
  logic [AW-2:0] count;
  logic          err;

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] addr;
    int            edge_n;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .flush(flush), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .full(full), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used to check strobe latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data || cyc != mon_e.edge_n) begin
          failures = failures + 1;
          $display("FAIL write actual addr=%h data=%h edge=%0d required addr=%h data=%h edge=%0d",
                   mem_addr, mem_wdata, cyc, mon_e.addr, mon_e.data, mon_e.edge_n);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one request; returns at the negedge of the ENC cycle.
  task automatic send(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg,
                      input logic push, input logic [31:0] w, input logic [AW-1:0] a);
    logic acc;
    acc = 1'b0;
    @(negedge clk);
    op_sel = op; rs = s; rt = t; rd = d; imm = im; target = tg; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    checks = checks + 1;
    if (!acc) begin
      failures = failures + 1;
      $display("FAIL accept actual=0 required=1");
    end else if (push) begin
      exp_q.push_back('{data: w, addr: a, edge_n: cyc + 2});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    op_sel = 4'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'd0; target = 26'd0;
    wait_cycles(3);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_mem_write", 32'(mem_write), 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // ADD r3 = r1 + r2
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0022_1820, 4'h0);
    chk("enc_in_ready", 32'(in_ready), 32'd0);
    wait_cycles(2);
    chk("add_count", 32'(count), 32'd1);

    // LW, JAL, JR sequence fills the four-word region
    send(4'd3, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b1, 32'h8FA8_0004, 4'h4);
    wait_cycles(2);
    send(4'd10, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h000_0010, 1'b1, 32'h0C00_0010, 4'h8);
    wait_cycles(2);
    send(4'd2, 5'd31, 5'd5, 5'd6, 16'h1234, 26'h0, 1'b1, 32'h03E0_0008, 4'hC);
    wait_cycles(2);
    chk("full_count", 32'(count), 32'd4);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);

    // Fifth request held while full: never accepted
    in_valid = 1'b1; op_sel = 4'd0; rs = 5'd1; rt = 5'd1; rd = 5'd1;
    for (int i = 0; i < 5; i++) begin
      wait_cycles(1);
      chk("held_in_ready", 32'(in_ready), 32'd0);
    end
    chk("held_count", 32'(count), 32'd4);
    chk("hold_addr", 32'(mem_addr), 32'hC);
    chk("hold_wdata", mem_wdata, 32'h03E0_0008);

    // Flush with in_valid in IDLE: flush wins
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    wait_cycles(1);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_full", 32'(full), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);

    // AND after flush lands at base
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1, 32'h0085_3024, 4'h0);
    wait_cycles(2);
    chk("and_count", 32'(count), 32'd1);

    // BEQ with flush during ENC: write completes, then rewind
    send(4'd5, 5'd1, 5'd2, 5'd9, 16'hFFFE, 26'h0, 1'b1, 32'h1022_FFFE, 4'h4);
    flush = 1'b1;
    wait_cycles(1);
    flush = 1'b0;
    wait_cycles(1);
    chk("flush_enc_count", 32'(count), 32'd0);
    send(4'd4, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0, 1'b1, 32'hAC43_0010, 4'h0);
    wait_cycles(2);
    chk("sw_count", 32'(count), 32'd1);

    // Illegal op 13
`ifdef ENCODER_ILLEGAL_CHECK_EN
    send(4'd13, 5'd3, 5'd3, 5'd3, 16'hABCD, 26'h0, 1'b0, 32'h0, 4'h0);
    #1;
    chk("illegal_err_pulse", 32'(err), 32'd1);
    wait_cycles(1);
    chk("illegal_err_clear", 32'(err), 32'd0);
    wait_cycles(1);
    chk("illegal_count", 32'(count), 32'd1);
`else
    send(4'd13, 5'd3, 5'd3, 5'd3, 16'hABCD, 26'h0, 1'b1, 32'h0000_0000, 4'h4);
    #1;
    chk("illegal_err", 32'(err), 32'd0);
    wait_cycles(2);
    chk("illegal_count", 32'(count), 32'd2);
`endif

    // Reset during ENC abandons the write
    send(4'd0, 5'd9, 5'd9, 5'd9, 16'h0, 26'h0, 1'b0, 32'h0, 4'h0);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_enc_mem_write", 32'(mem_write), 32'd0);
    chk("rst_enc_count", 32'(count), 32'd0);
    chk("rst_enc_wdata", mem_wdata, 32'd0);
    chk("rst_enc_addr", 32'(mem_addr), 32'd0);
    chk("rst_enc_err", 32'(err), 32'd0);
    wait_cycles(2);
    rst = 1'b0;

    // Refill from base
    send(4'd8, 5'd7, 5'd9, 5'd1, 16'h00FF, 26'h0, 1'b1, 32'h30E9_00FF, 4'h0);
    wait_cycles(2);
    send(4'd6, 5'd3, 5'd4, 5'd0, 16'h0008, 26'h0, 1'b1, 32'h1464_0008, 4'h4);
    wait_cycles(2);
    send(4'd9, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FF_FFFF, 1'b1, 32'h0BFF_FFFF, 4'h8);
    wait_cycles(2);
    send(4'd7, 5'd0, 5'd1, 5'd2, 16'h8000, 26'h0, 1'b1, 32'h2001_8000, 4'hC);
    wait_cycles(3);
    chk("refill_count", 32'(count), 32'd4);
    chk("refill_full", 32'(full), 32'd1);
    chk("refill_hold_addr", 32'(mem_addr), 32'hC);
    chk("refill_hold_wdata", mem_wdata, 32'h2001_8000);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
